// File: rtl/mem_bus_arb.sv
// ---------------------------------------------------------------------------
// mem_bus_arb
//   Merges the CPU core's instruction-RAM (iram_*) and data-RAM (dram_*)
//   request ports onto one SRAM-like memory port (mem_*) with req/addr_ok/
//   data_ok handshakes. The source of every accepted request is recorded in
//   an in-order FIFO so each mem_data_ok is routed back to the issuing port.
//
// Parameters
//   XLEN        data/address width
//   OSTD_DEPTH  max accepted-but-unanswered requests (power of 2, >= 1)
//
// Ports
//   clk, rst_b                    clock; synchronous reset, active HIGH
//   iram_req/write/wstrb/addr/wdata   instruction request + payload (in)
//   iram_addr_ok/data_ok/rdata        instruction accept / response (out)
//   dram_*                            same set for the data port
//   mem_req/write/wstrb/addr/wdata    merged request to memory (out)
//   mem_addr_ok/data_ok/rdata         memory accept / in-order response (in)
//
// Configuration macros
//   ARB_RR_EN              round-robin arbitration on contention; when
//                          undefined the data port wins contention so
//                          loads/stores are never starved by fetch.
//   MEM_BUS_ARB_SVA        enables the simulation check that flags a
//                          mem_data_ok arriving with no request outstanding.
// ---------------------------------------------------------------------------
module mem_bus_arb #(
    parameter int XLEN       = 32,
    parameter int OSTD_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic                iram_req,
    input  logic                iram_write,
    input  logic [XLEN/8-1:0]   iram_wstrb,
    input  logic [XLEN-1:0]     iram_addr,
    input  logic [XLEN-1:0]     iram_wdata,
    output logic                iram_addr_ok,
    output logic                iram_data_ok,
    output logic [XLEN-1:0]     iram_rdata,
    input  logic                dram_req,
    input  logic                dram_write,
    input  logic [XLEN/8-1:0]   dram_wstrb,
    input  logic [XLEN-1:0]     dram_addr,
    input  logic [XLEN-1:0]     dram_wdata,
    output logic                dram_addr_ok,
    output logic                dram_data_ok,
    output logic [XLEN-1:0]     dram_rdata,
    output logic                mem_req,
    output logic                mem_write,
    output logic [XLEN/8-1:0]   mem_wstrb,
    output logic [XLEN-1:0]     mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic                mem_addr_ok,
    input  logic                mem_data_ok,
    input  logic [XLEN-1:0]     mem_rdata
);

    localparam int CNT_W = $clog2(OSTD_DEPTH + 1);
    localparam int PTR_W = (OSTD_DEPTH > 1) ? $clog2(OSTD_DEPTH) : 1;

    typedef enum logic [1:0] {GNT_NONE, GNT_I, GNT_D} grant_t;

    // Lock FSM: while a request waits for mem_addr_ok the grant is frozen
    // so the payload cannot switch ports mid-handshake.
    logic   lock_reg, lock_next;
    grant_t grant_reg, grant_next;
    grant_t grant;

    // Source FIFO: 0 = instruction port, 1 = data port.
    logic             src_mem [OSTD_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic full, req_any, req_int, fire, pop, push_src, head_src;

`ifdef ARB_RR_EN
    logic rr_last_reg;   // source of the most recent accepted request
`endif

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OSTD_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (cnt_reg == CNT_W'(OSTD_DEPTH));
    assign req_any  = iram_req | dram_req;
    assign req_int  = req_any & ~full;
    assign fire     = req_int & mem_addr_ok;
    assign push_src = (grant == GNT_D);
    assign pop      = mem_data_ok & (cnt_reg != '0);
    assign head_src = src_mem[rd_ptr_reg];

    // Arbitration: only re-evaluated when no handshake is pending.
    always_comb begin
        grant = GNT_NONE;
        if (lock_reg) begin
            grant = grant_reg;
        end else if (iram_req && dram_req) begin
`ifdef ARB_RR_EN
            grant = rr_last_reg ? GNT_I : GNT_D;
`else
            grant = GNT_D;
`endif
        end else if (dram_req) begin
            grant = GNT_D;
        end else if (iram_req) begin
            grant = GNT_I;
        end
    end

    always_comb begin
        lock_next  = lock_reg;
        grant_next = grant_reg;
        if (req_int && !mem_addr_ok) begin
            lock_next  = 1'b1;
            grant_next = grant;
        end else if (fire) begin
            lock_next  = 1'b0;
            grant_next = GNT_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            lock_reg  <= 1'b0;
            grant_reg <= GNT_NONE;
        end else begin
            lock_reg  <= lock_next;
            grant_reg <= grant_next;
        end
    end

    // Push and pop may coincide; the count then stays put.
    always_comb begin
        cnt_next = cnt_reg;
        case ({fire, pop})
            2'b10:   cnt_next = cnt_reg + CNT_W'(1);
            2'b01:   cnt_next = cnt_reg - CNT_W'(1);
            default: cnt_next = cnt_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            cnt_reg    <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
            if (fire) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
        end
    end

    // Storage needs no reset: entries are only read behind a valid count.
    always_ff @(posedge clk) begin
        if (fire && !rst_b) src_mem[wr_ptr_reg] <= push_src;
    end

`ifdef ARB_RR_EN
    always_ff @(posedge clk) begin
        if (rst_b)     rr_last_reg <= 1'b0;
        else if (fire) rr_last_reg <= push_src;
    end
`endif

    // Request path: payload of the granted port, zero when nothing granted.
    always_comb begin
        mem_write = 1'b0;
        mem_wstrb = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!rst_b) begin
            case (grant)
                GNT_I: begin
                    mem_write = iram_write;
                    mem_wstrb = iram_wstrb;
                    mem_addr  = iram_addr;
                    mem_wdata = iram_wdata;
                end
                GNT_D: begin
                    mem_write = dram_write;
                    mem_wstrb = dram_wstrb;
                    mem_addr  = dram_addr;
                    mem_wdata = dram_wdata;
                end
                default: ;
            endcase
        end
    end

    assign mem_req      = req_int & ~rst_b;
    assign iram_addr_ok = fire & (grant == GNT_I) & ~rst_b;
    assign dram_addr_ok = fire & (grant == GNT_D) & ~rst_b;
    assign iram_data_ok = pop & ~head_src & ~rst_b;
    assign dram_data_ok = pop & head_src & ~rst_b;
    assign iram_rdata   = rst_b ? '0 : mem_rdata;
    assign dram_rdata   = rst_b ? '0 : mem_rdata;

`ifdef MEM_BUS_ARB_SVA
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            assert (!(mem_data_ok && cnt_reg == '0))
                else $error("mem_bus_arb: mem_data_ok with no outstanding request");
        end
    end
`endif

endmodule

// File: tb/tb_mem_bus_arb.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arb
//   Directed test of mem_bus_arb (XLEN=32, OSTD_DEPTH=2). A transaction-level
//   model (queue of outstanding sources, a "held" request, last winner)
//   predicts every output each cycle; directed steps add literal checks.
// ---------------------------------------------------------------------------
module tb_mem_bus_arb;
    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst_b = 1'b1;
    logic iram_req = 0, iram_write = 0, dram_req = 0, dram_write = 0;
    logic [3:0]  iram_wstrb = 0, dram_wstrb = 0;
    logic [31:0] iram_addr = 0, iram_wdata = 0, dram_addr = 0, dram_wdata = 0;
    logic        iram_addr_ok, iram_data_ok, dram_addr_ok, dram_data_ok;
    logic [31:0] iram_rdata, dram_rdata;
    logic        mem_req, mem_write;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok = 0, mem_data_ok = 0;
    logic [31:0] mem_rdata = 0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_bus_arb #(.XLEN(XLEN), .OSTD_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_b(rst_b),
        .iram_req(iram_req), .iram_write(iram_write), .iram_wstrb(iram_wstrb),
        .iram_addr(iram_addr), .iram_wdata(iram_wdata),
        .iram_addr_ok(iram_addr_ok), .iram_data_ok(iram_data_ok), .iram_rdata(iram_rdata),
        .dram_req(dram_req), .dram_write(dram_write), .dram_wstrb(dram_wstrb),
        .dram_addr(dram_addr), .dram_wdata(dram_wdata),
        .dram_addr_ok(dram_addr_ok), .dram_data_ok(dram_data_ok), .dram_rdata(dram_rdata),
        .mem_req(mem_req), .mem_write(mem_write), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
        end
    endtask

    // One bus cycle: inputs applied at the falling edge, outputs settle by +3.
    task automatic cyc(input logic r, input logic ir, input logic [31:0] ia,
                       input logic dr, input logic [31:0] da,
                       input logic aok, input logic dok, input logic [31:0] rd);
        @(negedge clk);
        rst_b = r;
        iram_req = ir;  iram_addr = ia; iram_wdata = ia ^ 32'h0F0F0F0F;
        iram_write = 1'b0; iram_wstrb = 4'h0;
        dram_req = dr;  dram_addr = da; dram_wdata = da ^ 32'hA5A5A5A5;
        dram_write = 1'b1; dram_wstrb = 4'hF;
        mem_addr_ok = aok; mem_data_ok = dok; mem_rdata = rd;
        #3;
        $display("cyc t=%0t rst=%b ireq=%b ia=%h dreq=%b da=%h aok=%b dok=%b | mreq=%b maddr=%h iaok=%b daok=%b idok=%b ddok=%b",
                 $time, r, ir, ia, dr, da, aok, dok, mem_req, mem_addr,
                 iram_addr_ok, dram_addr_ok, iram_data_ok, dram_data_ok);
    endtask

    // ---------------- transaction-level model + per-cycle compare ----------
    bit q[$];          // sources of accepted, unanswered requests (1 = data)
    bit held = 0;      // a request was offered but not accepted last cycle
    bit held_src = 0;
    bit rr_last = 0;

    always begin
        bit any, full, src, gnt, ereq, fire, pop, hd;
        logic [31:0] eaddr, ewdata;
        logic [3:0]  ewstrb;
        logic        ewrite;
        @(negedge clk);
        #3;
        if (rst_b) begin
            check("rst_mem_req", mem_req, 0);
            check("rst_mem_addr", mem_addr, 0);
            check("rst_addr_ok", {iram_addr_ok, dram_addr_ok}, 0);
            check("rst_data_ok", {iram_data_ok, dram_data_ok}, 0);
            check("rst_rdata", {iram_rdata, dram_rdata}, 0);
            q.delete();
            held = 0; held_src = 0; rr_last = 0;
        end else begin
            any  = iram_req | dram_req;
            full = (q.size() == DEPTH);
            if (held) src = held_src;
`ifdef ARB_RR_EN
            else if (iram_req && dram_req) src = ~rr_last;
`else
            else if (iram_req && dram_req) src = 1'b1;
`endif
            else src = dram_req;
            gnt  = held | any;
            ereq = any & ~full;
            fire = ereq & mem_addr_ok;
            pop  = mem_data_ok && (q.size() > 0);
            hd   = pop ? q[0] : 1'b0;
            ewrite = gnt ? (src ? dram_write : iram_write) : 1'b0;
            ewstrb = gnt ? (src ? dram_wstrb : iram_wstrb) : 4'h0;
            eaddr  = gnt ? (src ? dram_addr  : iram_addr)  : 32'h0;
            ewdata = gnt ? (src ? dram_wdata : iram_wdata) : 32'h0;
            check("m_mem_req", mem_req, ereq);
            check("m_mem_payload", {mem_write, mem_wstrb, mem_addr, mem_wdata},
                  {ewrite, ewstrb, eaddr, ewdata});
            check("m_iram_addr_ok", iram_addr_ok, fire & ~src);
            check("m_dram_addr_ok", dram_addr_ok, fire & src);
            check("m_iram_data_ok", iram_data_ok, pop & ~hd);
            check("m_dram_data_ok", dram_data_ok, pop & hd);
            check("m_rdata", {iram_rdata, dram_rdata}, {mem_rdata, mem_rdata});
            if (pop) void'(q.pop_front());
            if (fire) begin
                q.push_back(src);
                rr_last = src;
                held = 0;
            end else if (ereq) begin
                held = 1;
                held_src = src;
            end
        end
    end

    // ---------------- directed stimulus with literal expectations ----------
    initial begin
        // reset state: outputs forced low even with a request present
        cyc(1, 1, 32'h100, 0, 0, 1, 0, 32'h0);
        check("L_reset_mem_req", mem_req, 0);
        check("L_reset_iaok", iram_addr_ok, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);

        // 1: single instruction read
        cyc(0, 1, 32'h100, 0, 0, 1, 0, 0);
        check("L1_mem_addr", mem_addr, 32'h100);
        check("L1_iaok", iram_addr_ok, 1);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF);
        check("L1_idok", iram_data_ok, 1);
        check("L1_irdata", iram_rdata, 32'hDEADBEEF);
        check("L1_ddok", dram_data_ok, 0);

        // 2: contention, data port first, responses routed in order
        cyc(0, 1, 32'h4, 1, 32'h2000, 1, 0, 0);
        check("L2_first_addr", mem_addr, 32'h2000);
        check("L2_daok", dram_addr_ok, 1);
        cyc(0, 1, 32'h4, 0, 0, 1, 0, 0);
        check("L2_second_addr", mem_addr, 32'h4);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h11111111);
        check("L2_ddok", dram_data_ok, 1);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h22222222);
        check("L2_idok", iram_data_ok, 1);
        // last winner now data port; contention again
        cyc(0, 0, 0, 1, 32'h3000, 1, 0, 0);
        cyc(0, 1, 32'h8, 1, 32'h3004, 1, 0, 0);
`ifdef ARB_RR_EN
        check("L2_rr_addr", mem_addr, 32'h8);
`else
        check("L2_fixed_addr", mem_addr, 32'h3004);
`endif
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h1);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h2);

        // 3: stall locks the instruction grant while data port arrives
        cyc(0, 1, 32'h40, 0, 0, 0, 0, 0);
        cyc(0, 1, 32'h40, 1, 32'h5000, 0, 0, 0);
        check("L3_locked_addr", mem_addr, 32'h40);
        cyc(0, 1, 32'h40, 1, 32'h5000, 0, 0, 0);
        cyc(0, 1, 32'h40, 1, 32'h5000, 1, 0, 0);
        check("L3_accept_i", iram_addr_ok, 1);
        cyc(0, 0, 0, 1, 32'h5000, 1, 0, 0);
        check("L3_then_d", mem_addr, 32'h5000);
        check("L3_daok", dram_addr_ok, 1);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h3);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h4);

        // 4: full at two outstanding
        cyc(0, 1, 32'h10, 0, 0, 1, 0, 0);
        cyc(0, 1, 32'h14, 0, 0, 1, 0, 0);
        cyc(0, 1, 32'h18, 0, 0, 1, 0, 0);
        check("L4_full_req", mem_req, 0);
        check("L4_full_iaok", iram_addr_ok, 0);
        cyc(0, 1, 32'h18, 0, 0, 1, 1, 32'h5);
        check("L4_pop_idok", iram_data_ok, 1);
        check("L4_still_full", mem_req, 0);
        cyc(0, 1, 32'h18, 0, 0, 1, 0, 0);
        check("L4_third_req", mem_req, 1);
        check("L4_third_iaok", iram_addr_ok, 1);

        // 5: push+pop at cnt=1, spurious data_ok, reset mid-operation
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h6);
        cyc(0, 0, 0, 1, 32'h6000, 1, 1, 32'h7);
        check("L5_pp_idok", iram_data_ok, 1);
        check("L5_pp_daok", dram_addr_ok, 1);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h8);
        check("L5_ddok", dram_data_ok, 1);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h9);
        check("L5_spurious", {iram_data_ok, dram_data_ok}, 0);
        cyc(0, 1, 32'h20, 0, 0, 1, 0, 0);
        cyc(0, 1, 32'h24, 0, 0, 0, 0, 0);
        cyc(1, 1, 32'h24, 0, 0, 0, 0, 0);
        check("L5_rst_req", mem_req, 0);
        cyc(0, 0, 32'h0, 1, 32'h7000, 0, 0, 0);
        check("L5_lock_cleared", mem_addr, 32'h7000);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'hA);
        check("L5_late_dok", {iram_data_ok, dram_data_ok}, 0);
        cyc(0, 0, 0, 1, 32'h7000, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'hB);
        check("L5_after_rst_ddok", dram_data_ok, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        #5;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
